// File: rtl/series_scan_ctrl_pkg.sv
// Shared encodings for the serial scan controller: one-hot FSM states and
// the detector latency selectors.
package series_scan_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_CLR    = 5'b00010,
    ST_SHIFT  = 5'b00100,
    ST_DRAIN  = 5'b01000,
    ST_REPORT = 5'b10000
  } state_e;

  localparam int DET_LAT_MEALY = 0;
  localparam int DET_LAT_MOORE = 1;

endpackage

// File: rtl/series_scan_ctrl.sv
// Feeds a parallel word MSB-first into a serial pattern detector, clearing the
// detector first, and reports how many matches landed inside that word.
module series_scan_ctrl
  import series_scan_ctrl_pkg::*;
#(
  parameter int W       = 8,
  parameter int DET_LAT = DET_LAT_MEALY,
  localparam int CW     = $clog2(W + 1),
  localparam int PW     = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  word_in,
  input  logic          word_valid,
  output logic          word_ready,
  output logic          det_rst_n,
  output logic          series,
  input  logic          detect,
  output logic [CW-1:0] match_cnt,
  output logic [PW-1:0] first_pos,
  output logic          no_match,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [W-1:0]  shreg_q;
  logic [PW-1:0] idx_q;
  logic          det_rst_q;
  logic          in_win;
  logic [PW-1:0] bit_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // DRAIN lasts a single cycle: the detector latency is either 0 or 1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (word_valid) state_d = ST_CLR;
      ST_CLR:    state_d = ST_SHIFT;
      ST_SHIFT:  if (idx_q == PW'(W - 1))
                   state_d = (DET_LAT == DET_LAT_MEALY) ? ST_REPORT : ST_DRAIN;
      ST_DRAIN:  state_d = ST_REPORT;
      ST_REPORT: if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_ready = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    res_valid  = (state_q == ST_REPORT);
    series     = (state_q == ST_SHIFT) & shreg_q[W-1];
    no_match   = (match_cnt == '0);
    det_rst_n  = det_rst_q;
  end

  // A pulse seen now completes the pattern at bit idx-DET_LAT; in DRAIN that is the last bit.
  always_comb begin
    in_win = 1'b0;
    bit_k  = '0;
    if (state_q == ST_SHIFT && int'(idx_q) >= DET_LAT) begin
      in_win = 1'b1;
      bit_k  = idx_q - PW'(DET_LAT);
    end else if (state_q == ST_DRAIN) begin
      in_win = 1'b1;
      bit_k  = PW'(W - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      match_cnt <= '0;
      first_pos <= '0;
      det_rst_q <= 1'b0;
    end else begin
      det_rst_q <= (state_d != ST_CLR);
      case (state_q)
        ST_IDLE: if (word_valid) begin
          match_cnt <= '0;
          first_pos <= '0;
        end
        ST_CLR:   idx_q <= '0;
        ST_SHIFT: idx_q <= idx_q + 1'b1;
        default:  ;
      endcase
      if (in_win && detect) begin
        if (match_cnt != CW'(W)) match_cnt <= match_cnt + 1'b1;
        if (match_cnt == '0)     first_pos <= bit_k;
      end
    end
  end

  // Word storage is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && word_valid) shreg_q <= word_in;
    else if (state_q == ST_SHIFT)         shreg_q <= {shreg_q[W-2:0], 1'b0};
  end

endmodule

// File: tb/tb_series_scan_ctrl.sv
// Bench: a Mealy and a Moore controller, each driving its own behavioural
// 1011 detector, checked against hand tables and a reference bit scan.
module tb_series_scan_ctrl;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0][7:0] word_in;
  logic [1:0]      word_valid, word_ready, det_rst_n, series, detect;
  logic [1:0]      no_match, res_valid, res_ready, busy, force_det;
  logic [1:0][3:0] match_cnt;
  logic [1:0][2:0] first_pos;

  logic [1:0][2:0] hist;
  logic [1:0]      hit;
  logic            moore_q;

  typedef struct { int d; logic [7:0] word; int cnt; int first; } vec_t;
  typedef struct { int d; int cnt; int first; int lat; } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    series_scan_ctrl #(.W(8), .DET_LAT(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .word_in(word_in[g]), .word_valid(word_valid[g]),
      .word_ready(word_ready[g]), .det_rst_n(det_rst_n[g]), .series(series[g]),
      .detect(detect[g]), .match_cnt(match_cnt[g]), .first_pos(first_pos[g]),
      .no_match(no_match[g]), .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .busy(busy[g])
    );
  end

  // Behavioural detect_1011 (overlapping): dut0 Mealy, dut1 Moore.
  always_comb begin
    hit = '0;
    for (int d = 0; d < 2; d++) hit[d] = ({hist[d], series[d]} == 4'b1011);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      moore_q <= 1'b0;
    end else begin
      for (int d = 0; d < 2; d++)
        hist[d] <= det_rst_n[d] ? {hist[d][1:0], series[d]} : 3'b000;
      moore_q <= det_rst_n[1] ? hit[1] : 1'b0;
    end
  end

  assign detect[0] = hit[0] | force_det[0];
  assign detect[1] = moore_q | force_det[1];

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, act, exp);
  endtask

  function automatic void ref_scan(input logic [7:0] w, output int cnt, output int first);
    logic [3:0] win;
    cnt = 0;
    first = 0;
    for (int k = 3; k < 8; k++) begin
      win = {w[10-k], w[9-k], w[8-k], w[7-k]};
      if (win == 4'b1011) begin
        if (cnt == 0) first = k;
        cnt++;
      end
    end
  endfunction

  task automatic check_reset(input int d);
    chk("rst word_ready", d, int'(word_ready[d]), 1);
    chk("rst det_rst_n",  d, int'(det_rst_n[d]),  0);
    chk("rst series",     d, int'(series[d]),     0);
    chk("rst match_cnt",  d, int'(match_cnt[d]),  0);
    chk("rst first_pos",  d, int'(first_pos[d]),  0);
    chk("rst no_match",   d, int'(no_match[d]),   1);
    chk("rst res_valid",  d, int'(res_valid[d]),  0);
    chk("rst busy",       d, int'(busy[d]),       0);
  endtask

  task automatic compare_result(input int n, input bit got);
    exp_t e;
    e = exp_q.pop_front();
    chk("latency",   e.d, got ? n : -1, e.lat);
    chk("match_cnt", e.d, int'(match_cnt[e.d]), e.cnt);
    chk("first_pos", e.d, int'(first_pos[e.d]), e.first);
    chk("no_match",  e.d, int'(no_match[e.d]), (e.cnt == 0) ? 1 : 0);
  endtask

  task automatic run_word(input int d, input logic [7:0] w, input int ecnt, input int efirst);
    int n;
    bit got;
    exp_q.push_back('{d: d, cnt: ecnt, first: efirst, lat: 10 + d});
    @(negedge clk);
    word_in[d] = w;
    word_valid[d] = 1'b1;
    res_ready[d] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        chk("ready low after accept", d, int'(word_ready[d]), 0);
        word_valid[d] = 1'b0;
        word_in[d] = ~w;
      end
      got = res_valid[d];
    end
    compare_result(n, got);
    @(posedge clk);
    #1;
    chk("retire to idle", d, int'({busy[d], word_ready[d]}), 1);
    res_ready[d] = 1'b0;
  endtask

  initial begin
    vec_t vec[16];
    int   n, rc, rf;
    bit   ok, saw;
    logic [7:0] rw;

    vec[0]  = '{0, 8'b1011_0000, 1, 3};
    vec[1]  = '{1, 8'b0000_1011, 1, 7};
    vec[2]  = '{0, 8'b0000_1011, 1, 7};
    vec[3]  = '{1, 8'b1011_0000, 1, 3};
    vec[4]  = '{0, 8'b1011_0111, 2, 3};
    vec[5]  = '{1, 8'b1011_0111, 2, 3};
    vec[6]  = '{0, 8'h00, 0, 0};
    vec[7]  = '{0, 8'hFF, 0, 0};
    vec[8]  = '{1, 8'h00, 0, 0};
    vec[9]  = '{1, 8'hFF, 0, 0};
    vec[10] = '{0, 8'b0000_0101, 0, 0};
    vec[11] = '{0, 8'b1000_0000, 0, 0};
    vec[12] = '{1, 8'b0000_0101, 0, 0};
    vec[13] = '{1, 8'b1000_0000, 0, 0};
    vec[14] = '{0, 8'b0101_1000, 1, 4};
    vec[15] = '{1, 8'b0101_1000, 1, 4};

    rst_n = 1'b0;
    word_in = '0;
    word_valid = '0;
    res_ready = '0;
    force_det = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) run_word(vec[i].d, vec[i].word, vec[i].cnt, vec[i].first);

    for (int i = 0; i < 16; i++) begin
      rw = 8'($urandom);
      ref_scan(rw, rc, rf);
      run_word(i % 2, rw, rc, rf);
    end

    // Backpressure, then retire with a competing word on the same edge.
    exp_q.push_back('{d: 0, cnt: 1, first: 3, lat: 10});
    @(negedge clk);
    word_in[0] = 8'b1011_0000;
    word_valid[0] = 1'b1;
    res_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    word_valid[0] = 1'b0;
    n = 1;
    while (!res_valid[0] && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    compare_result(n, res_valid[0]);
    word_in[0] = 8'b0000_1011;
    word_valid[0] = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!(res_valid[0] && match_cnt[0] == 4'd1 && first_pos[0] == 3'd3 &&
            !word_ready[0] && busy[0])) ok = 1'b0;
    end
    chk("hold under backpressure", 0, int'(ok), 1);
    @(negedge clk) res_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("release res_valid", 0, int'(res_valid[0]), 0);
    chk("release busy",      0, int'(busy[0]), 0);
    chk("release word_ready", 0, int'(word_ready[0]), 1);
    word_valid[0] = 1'b0;
    res_ready[0] = 1'b0;

    // Spurious detect while idle must leave the held result alone.
    @(negedge clk) force_det[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold match_cnt", 0, int'(match_cnt[0]), 1);
    chk("idle hold first_pos", 0, int'(first_pos[0]), 3);
    force_det[0] = 1'b0;

    // Asynchronous reset while shifting bit 4.
    @(negedge clk);
    word_in[0] = 8'b1011_0000;
    word_valid[0] = 1'b1;
    res_ready[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) word_valid[0] = 1'b0;
    end
    chk("mid-word partial count", 0, int'(match_cnt[0]), 1);
    rst_n = 1'b0;
    #1;
    check_reset(0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    saw = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (res_valid[0]) saw = 1'b1;
    end
    chk("no result after reset", 0, int'(saw), 0);
    res_ready[0] = 1'b0;
    run_word(0, 8'b1011_0111, 2, 3);
    run_word(1, 8'b0000_1011, 1, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
